// File: rtl/nf10_output_demux.sv
// One-in, five-out AXI-Stream demux: a single holding register fans each beat out to the
// ports named by the packet's SOP destination mask. Optional NF10_OUTPUT_DEMUX_DROP_CNT_EN adds drop_count.
module nf10_output_demux #(
  parameter int C_M_AXIS_DATA_WIDTH  = 256,
  parameter int C_S_AXIS_DATA_WIDTH  = 256,
  parameter int C_M_AXIS_TUSER_WIDTH = 128,
  parameter int C_S_AXIS_TUSER_WIDTH = 128,
  parameter int NUM_QUEUES           = 5,
  parameter int DST_POS              = 24
) (
  input  logic                              axi_aclk,
  input  logic                              axi_resetn,

  input  logic [C_S_AXIS_DATA_WIDTH-1:0]    s_axis_tdata,
  input  logic [C_S_AXIS_DATA_WIDTH/8-1:0]  s_axis_tstrb,
  input  logic [C_S_AXIS_TUSER_WIDTH-1:0]   s_axis_tuser,
  input  logic                              s_axis_tvalid,
  input  logic                              s_axis_tlast,
  output logic                              s_axis_tready,

  output logic [C_M_AXIS_DATA_WIDTH-1:0]    m_axis_tdata_0,
  output logic [C_M_AXIS_DATA_WIDTH/8-1:0]  m_axis_tstrb_0,
  output logic [C_M_AXIS_TUSER_WIDTH-1:0]   m_axis_tuser_0,
  output logic                              m_axis_tvalid_0,
  output logic                              m_axis_tlast_0,
  input  logic                              m_axis_tready_0,

  output logic [C_M_AXIS_DATA_WIDTH-1:0]    m_axis_tdata_1,
  output logic [C_M_AXIS_DATA_WIDTH/8-1:0]  m_axis_tstrb_1,
  output logic [C_M_AXIS_TUSER_WIDTH-1:0]   m_axis_tuser_1,
  output logic                              m_axis_tvalid_1,
  output logic                              m_axis_tlast_1,
  input  logic                              m_axis_tready_1,

  output logic [C_M_AXIS_DATA_WIDTH-1:0]    m_axis_tdata_2,
  output logic [C_M_AXIS_DATA_WIDTH/8-1:0]  m_axis_tstrb_2,
  output logic [C_M_AXIS_TUSER_WIDTH-1:0]   m_axis_tuser_2,
  output logic                              m_axis_tvalid_2,
  output logic                              m_axis_tlast_2,
  input  logic                              m_axis_tready_2,

  output logic [C_M_AXIS_DATA_WIDTH-1:0]    m_axis_tdata_3,
  output logic [C_M_AXIS_DATA_WIDTH/8-1:0]  m_axis_tstrb_3,
  output logic [C_M_AXIS_TUSER_WIDTH-1:0]   m_axis_tuser_3,
  output logic                              m_axis_tvalid_3,
  output logic                              m_axis_tlast_3,
  input  logic                              m_axis_tready_3,

  output logic [C_M_AXIS_DATA_WIDTH-1:0]    m_axis_tdata_4,
  output logic [C_M_AXIS_DATA_WIDTH/8-1:0]  m_axis_tstrb_4,
  output logic [C_M_AXIS_TUSER_WIDTH-1:0]   m_axis_tuser_4,
  output logic                              m_axis_tvalid_4,
  output logic                              m_axis_tlast_4,
  input  logic                              m_axis_tready_4,

`ifdef NF10_OUTPUT_DEMUX_DROP_CNT_EN
  output logic [31:0]                       drop_count,
`endif
  output logic                              state_dbg
);

  // Handshake rule on every port: a beat moves on the rising edge where tvalid and tready
  // are both high; tvalid never waits on tready, and once raised holds its beat until taken.

  typedef enum logic [0:0] {IDLE = 1'b0, IN_PKT = 1'b1} state_t;

  state_t                          state, state_nxt;
  logic [NUM_QUEUES-1:0]           pending, pending_nxt;
  logic [NUM_QUEUES-1:0]           latched_mask, latched_mask_nxt;
  logic [NUM_QUEUES-1:0]           tready_vec, owed, dst_field, beat_mask;
  logic                            free, accept, sop, load;

  logic [C_S_AXIS_DATA_WIDTH-1:0]   hold_data;
  logic [C_S_AXIS_DATA_WIDTH/8-1:0] hold_strb;
  logic [C_S_AXIS_TUSER_WIDTH-1:0]  hold_user;
  logic                             hold_last;

  assign tready_vec = {m_axis_tready_4, m_axis_tready_3, m_axis_tready_2,
                       m_axis_tready_1, m_axis_tready_0};
  assign dst_field  = s_axis_tuser[DST_POS +: NUM_QUEUES];

  // Ports that will still be waiting for the current beat after this edge.
  assign owed          = pending & ~tready_vec;
  assign free          = (owed == '0);
  assign s_axis_tready = free & axi_resetn;
  assign accept        = s_axis_tvalid & s_axis_tready;
  assign sop           = (state == IDLE);
  assign beat_mask     = sop ? dst_field : latched_mask;
  // A zero-mask beat is swallowed without touching the holding register.
  assign load          = accept & (beat_mask != '0);

  always_comb begin
    state_nxt        = state;
    latched_mask_nxt = latched_mask;
    pending_nxt      = owed;
    if (load) pending_nxt = beat_mask;
    if (accept) begin
      if (sop) latched_mask_nxt = dst_field;
      state_nxt = s_axis_tlast ? IDLE : IN_PKT;
    end
  end

  always_ff @(posedge axi_aclk or negedge axi_resetn) begin
    if (!axi_resetn) begin
      state        <= IDLE;
      pending      <= '0;
      latched_mask <= '0;
    end else begin
      state        <= state_nxt;
      pending      <= pending_nxt;
      latched_mask <= latched_mask_nxt;
    end
  end

  always_ff @(posedge axi_aclk) begin
    if (load) begin
      hold_data <= s_axis_tdata;
      hold_strb <= s_axis_tstrb;
      hold_user <= s_axis_tuser;
      hold_last <= s_axis_tlast;
    end
  end

`ifdef NF10_OUTPUT_DEMUX_DROP_CNT_EN
  always_ff @(posedge axi_aclk or negedge axi_resetn) begin
    if (!axi_resetn) drop_count <= '0;
    else if (accept && sop && (dst_field == '0)) drop_count <= drop_count + 32'd1;
  end
`endif

  assign state_dbg = state;

  assign m_axis_tvalid_0 = pending[0];
  assign m_axis_tvalid_1 = pending[1];
  assign m_axis_tvalid_2 = pending[2];
  assign m_axis_tvalid_3 = pending[3];
  assign m_axis_tvalid_4 = pending[4];

  assign m_axis_tdata_0 = hold_data;
  assign m_axis_tdata_1 = hold_data;
  assign m_axis_tdata_2 = hold_data;
  assign m_axis_tdata_3 = hold_data;
  assign m_axis_tdata_4 = hold_data;

  assign m_axis_tstrb_0 = hold_strb;
  assign m_axis_tstrb_1 = hold_strb;
  assign m_axis_tstrb_2 = hold_strb;
  assign m_axis_tstrb_3 = hold_strb;
  assign m_axis_tstrb_4 = hold_strb;

  assign m_axis_tuser_0 = hold_user;
  assign m_axis_tuser_1 = hold_user;
  assign m_axis_tuser_2 = hold_user;
  assign m_axis_tuser_3 = hold_user;
  assign m_axis_tuser_4 = hold_user;

  assign m_axis_tlast_0 = hold_last;
  assign m_axis_tlast_1 = hold_last;
  assign m_axis_tlast_2 = hold_last;
  assign m_axis_tlast_3 = hold_last;
  assign m_axis_tlast_4 = hold_last;

endmodule

// File: tb/tb_nf10_output_demux.sv
// Bench for nf10_output_demux: per-port expected-beat queues built from the routing rules,
// checked every cycle, plus directed scenarios with hand-computed counts.
module tb_nf10_output_demux;

  localparam int DW = 256;
  localparam int SW = 32;
  localparam int UW = 128;
  localparam int BW = DW + SW + UW + 1;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  // ---------------- DUT signals ----------------
  logic [DW-1:0] s_tdata;
  logic [SW-1:0] s_tstrb;
  logic [UW-1:0] s_tuser;
  logic          s_tvalid, s_tlast, s_tready;
  logic [DW-1:0] m_tdata [5];
  logic [SW-1:0] m_tstrb [5];
  logic [UW-1:0] m_tuser [5];
  logic [4:0]    m_tvalid, m_tlast, m_tready;
  logic          state_dbg;
`ifdef NF10_OUTPUT_DEMUX_DROP_CNT_EN
  logic [31:0]   drop_count;
`endif

  logic       rand_ready;
  logic [4:0] fixed_ready, rand_vec;
  assign m_tready = rand_ready ? rand_vec : fixed_ready;

  nf10_output_demux dut (
    .axi_aclk(clk), .axi_resetn(rst_n),
    .s_axis_tdata(s_tdata), .s_axis_tstrb(s_tstrb), .s_axis_tuser(s_tuser),
    .s_axis_tvalid(s_tvalid), .s_axis_tlast(s_tlast), .s_axis_tready(s_tready),
    .m_axis_tdata_0(m_tdata[0]), .m_axis_tstrb_0(m_tstrb[0]), .m_axis_tuser_0(m_tuser[0]),
    .m_axis_tvalid_0(m_tvalid[0]), .m_axis_tlast_0(m_tlast[0]), .m_axis_tready_0(m_tready[0]),
    .m_axis_tdata_1(m_tdata[1]), .m_axis_tstrb_1(m_tstrb[1]), .m_axis_tuser_1(m_tuser[1]),
    .m_axis_tvalid_1(m_tvalid[1]), .m_axis_tlast_1(m_tlast[1]), .m_axis_tready_1(m_tready[1]),
    .m_axis_tdata_2(m_tdata[2]), .m_axis_tstrb_2(m_tstrb[2]), .m_axis_tuser_2(m_tuser[2]),
    .m_axis_tvalid_2(m_tvalid[2]), .m_axis_tlast_2(m_tlast[2]), .m_axis_tready_2(m_tready[2]),
    .m_axis_tdata_3(m_tdata[3]), .m_axis_tstrb_3(m_tstrb[3]), .m_axis_tuser_3(m_tuser[3]),
    .m_axis_tvalid_3(m_tvalid[3]), .m_axis_tlast_3(m_tlast[3]), .m_axis_tready_3(m_tready[3]),
    .m_axis_tdata_4(m_tdata[4]), .m_axis_tstrb_4(m_tstrb[4]), .m_axis_tuser_4(m_tuser[4]),
    .m_axis_tvalid_4(m_tvalid[4]), .m_axis_tlast_4(m_tlast[4]), .m_axis_tready_4(m_tready[4]),
`ifdef NF10_OUTPUT_DEMUX_DROP_CNT_EN
    .drop_count(drop_count),
`endif
    .state_dbg(state_dbg)
  );

  // ---------------- scoreboard ----------------
  int checks = 0;
  int errors = 0;

  function automatic void chk(string name, logic [BW-1:0] act, logic [BW-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endfunction

  logic [BW-1:0] exp_q [5][$];
  bit            m_in_pkt = 1'b0;
  logic [4:0]    m_mask = '0;
  int            m_drops = 0;
  int            delivered [5];
  int            vcyc [5];
  int            ready_low = 0;
  int            cyc = 0;
  int            hs3_q [$];

  initial for (int n = 0; n < 5; n++) begin delivered[n] = 0; vcyc[n] = 0; end

  always @(posedge clk) begin
    #1;
    for (int n = 0; n < 5; n++) rand_vec[n] = ($urandom_range(0, 3) != 0);
  end

  // Compare process: outputs are stable at the falling edge.
  always @(negedge clk) begin
    logic exp_rdy;
    logic [BW-1:0] beat;
    cyc++;
    if (!rst_n) begin
      chk("reset_tvalid", BW'(m_tvalid), '0);
      chk("reset_s_tready", BW'(s_tready), '0);
      for (int n = 0; n < 5; n++) exp_q[n].delete();
      m_in_pkt = 1'b0;
    end else begin
      exp_rdy = 1'b1;
      for (int n = 0; n < 5; n++) begin
        chk($sformatf("tvalid_%0d", n), BW'(m_tvalid[n]), BW'(exp_q[n].size() != 0));
        if (exp_q[n].size() != 0 && !m_tready[n]) exp_rdy = 1'b0;
        if (m_tvalid[n]) vcyc[n]++;
        if (m_tvalid[n] && m_tready[n] && exp_q[n].size() != 0) begin
          beat = exp_q[n].pop_front();
          chk($sformatf("beat_%0d", n), {m_tdata[n], m_tstrb[n], m_tuser[n], m_tlast[n]}, beat);
          delivered[n]++;
          if (n == 3) hs3_q.push_back(cyc);
        end
      end
      chk("s_tready", BW'(s_tready), BW'(exp_rdy));
      if (!s_tready) ready_low++;
      if (s_tvalid && s_tready) begin
        if (!m_in_pkt) begin
          m_mask = s_tuser[24 +: 5];
          if (m_mask == '0) m_drops++;
        end
        for (int n = 0; n < 5; n++)
          if (m_mask[n]) exp_q[n].push_back({s_tdata, s_tstrb, s_tuser, s_tlast});
        m_in_pkt = !s_tlast;
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic send_beat(input logic [4:0] mask, input logic last);
    int waited = 0;
    for (int i = 0; i < DW / 32; i++) s_tdata[i*32 +: 32] = $urandom();
    for (int i = 0; i < UW / 32; i++) s_tuser[i*32 +: 32] = $urandom();
    s_tuser[24 +: 5] = mask;
    s_tstrb  = $urandom();
    s_tlast  = last;
    s_tvalid = 1'b1;
    forever begin
      @(negedge clk);
      if (s_tready) break;
      waited++;
      if (waited > 300) begin
        errors++;
        $display("FAIL accept_timeout actual=no_accept expected=accept_within_300");
        break;
      end
    end
    @(posedge clk);
    #1;
    s_tvalid = 1'b0;
  endtask

  task automatic send_pkt(input logic [4:0] sop_mask, input logic [4:0] later_mask,
                          input bit rand_later, input int nbeats, input int gap);
    logic [4:0] m;
    for (int b = 0; b < nbeats; b++) begin
      if (b == 0) m = sop_mask;
      else m = rand_later ? 5'($urandom()) : later_mask;
      send_beat(m, b == nbeats - 1);
      if (gap > 0) begin
        repeat (gap) @(posedge clk);
        #1;
      end
    end
  endtask

  function automatic int q_total();
    int t = 0;
    for (int n = 0; n < 5; n++) t += exp_q[n].size();
    return t;
  endfunction

  task automatic drain();
    int c = 0;
    while (q_total() != 0 && c < 2000) begin
      @(posedge clk);
      c++;
    end
    checks++;
    if (c >= 2000) begin
      errors++;
      $display("FAIL drain_timeout actual=%0d expected=0", q_total());
    end
    repeat (3) @(posedge clk);
    #1;
  endtask

  function automatic int sum_diff(input int a [5], input int b [5], input int skip);
    int t = 0;
    for (int n = 0; n < 5; n++) if (n != skip) t += a[n] - b[n];
    return t;
  endfunction

  // ---------------- main sequence ----------------
  int d0 [5];
  int v0 [5];
  int rl0, dr0, h0;
`ifdef NF10_OUTPUT_DEMUX_DROP_CNT_EN
  logic [31:0] dc0;
`endif

  initial begin
    rst_n = 1'b0; s_tvalid = 1'b0; s_tlast = 1'b0; s_tdata = '0; s_tstrb = '0; s_tuser = '0;
    rand_ready = 1'b0; fixed_ready = 5'b11111;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
`ifdef NF10_OUTPUT_DEMUX_DROP_CNT_EN
    chk("drop_count_reset", BW'(drop_count), '0);
`endif
    repeat (2) @(posedge clk);
    #1;

    // Unicast 3-beat packet to port 2
    d0 = delivered;
    send_pkt(5'b00100, 5'b00100, 1'b0, 3, 0);
    drain();
    chk("unicast_port2", BW'(delivered[2] - d0[2]), BW'(3));
    chk("unicast_others", BW'(sum_diff(delivered, d0, 2)), '0);

    // Multicast 1-beat to ports 0 and 4, port 4 stalled for 4 cycles
    fixed_ready = 5'b01111;
    @(posedge clk); #1;
    d0 = delivered; v0 = vcyc; rl0 = ready_low;
    send_beat(5'b10001, 1'b1);
    repeat (4) @(posedge clk);
    #1 fixed_ready = 5'b11111;
    drain();
    chk("mcast_port4_valid_cycles", BW'(vcyc[4] - v0[4]), BW'(5));
    chk("mcast_port0_valid_cycles", BW'(vcyc[0] - v0[0]), BW'(1));
    chk("mcast_ready_low_cycles", BW'(ready_low - rl0), BW'(4));
    chk("mcast_deliveries", BW'(delivered[0] - d0[0] + delivered[4] - d0[4]), BW'(2));

    // Routing latched at SOP; later beats carry a different field
    d0 = delivered;
    send_pkt(5'b00010, 5'b01000, 1'b0, 4, 1);
    drain();
    chk("latch_port1", BW'(delivered[1] - d0[1]), BW'(4));
    chk("latch_others", BW'(sum_diff(delivered, d0, 1)), '0);

    // Zero-mask packet dropped, following packet delivered
    d0 = delivered; v0 = vcyc; dr0 = m_drops;
`ifdef NF10_OUTPUT_DEMUX_DROP_CNT_EN
    dc0 = drop_count;
`endif
    send_pkt(5'b00000, 5'b00001, 1'b0, 2, 0);
    send_pkt(5'b00001, 5'b00001, 1'b0, 1, 0);
    drain();
    chk("drop_port0", BW'(delivered[0] - d0[0]), BW'(1));
    chk("drop_total_valid_cycles", BW'(sum_diff(vcyc, v0, -1)), BW'(1));
    chk("drop_model_count", BW'(m_drops - dr0), BW'(1));
`ifdef NF10_OUTPUT_DEMUX_DROP_CNT_EN
    chk("drop_count_inc", BW'(drop_count - dc0), BW'(1));
`endif

    // Throughput: 10 back-to-back single-beat packets to port 3
    h0 = hs3_q.size();
    for (int i = 0; i < 10; i++) send_beat(5'b01000, 1'b1);
    drain();
    chk("tput_count", BW'(hs3_q.size() - h0), BW'(10));
    if (hs3_q.size() - h0 == 10)
      chk("tput_consecutive", BW'(hs3_q[h0 + 9] - hs3_q[h0]), BW'(9));

    // Reset after beat 2 of a 4-beat packet
    send_beat(5'b00100, 1'b0);
    send_beat(5'b00100, 1'b0);
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    @(posedge clk); #1;
    d0 = delivered;
    send_beat(5'b00010, 1'b1);
    drain();
    chk("post_reset_port1", BW'(delivered[1] - d0[1]), BW'(1));
    chk("post_reset_others", BW'(sum_diff(delivered, d0, 1)), '0);

    // Randomized traffic with random per-port backpressure
    dr0 = m_drops;
`ifdef NF10_OUTPUT_DEMUX_DROP_CNT_EN
    dc0 = drop_count;
`endif
    rand_ready = 1'b1;
    for (int p = 0; p < 300; p++) begin
      logic [4:0] mk;
      mk = ($urandom_range(0, 7) == 0) ? 5'b00000 : 5'($urandom_range(1, 31));
      send_pkt(mk, 5'b00000, 1'b1, $urandom_range(1, 4), $urandom_range(0, 1));
    end
    drain();
    rand_ready = 1'b0;
    chk("random_queues_empty", BW'(q_total()), '0);
`ifdef NF10_OUTPUT_DEMUX_DROP_CNT_EN
    chk("random_drop_count", BW'(drop_count - dc0), BW'(m_drops - dr0));
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog actual=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

endmodule
